// File: rtl/softmax_norm.sv
// softmax_norm: normalises a vector of NUM_CLASSES exp values into probabilities.
// Each vector is collected and summed. Each element is then divided by the sum,
// one element at a time, using a bit-serial restoring divider. Each quotient is
// returned in the same unsigned Q format as the input.
// Optional feature: define SOFTMAX_ARGMAX_EN to add norm_argmax_out. This output
// carries the index of the largest input, with the lowest index winning on ties.
module softmax_norm #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACTION    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  norm_ready_in,
  input  logic                  norm_valid_in,
  input  logic [DATA_WIDTH-1:0] norm_data_in,
  input  logic                  norm_ready_out,
  output logic                  norm_valid_out,
  output logic [DATA_WIDTH-1:0] norm_data_out,
  output logic                  norm_last_out
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [$clog2(NUM_CLASSES)-1:0] norm_argmax_out
`endif
);

  localparam int KW    = $clog2(NUM_CLASSES);
  localparam int SUM_W = DATA_WIDTH + KW;
  localparam int QW    = DATA_WIDTH + FRACTION;
  localparam int CW    = $clog2(QW + 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_CLASSES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW);

  typedef enum logic [1:0] {COLLECT, DIVIDE, OUTPUT} state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic [SUM_W-1:0]      acc;
  logic [CW-1:0]         cnt;
  logic [QW-1:0]         dvd;
  logic [SUM_W-1:0]      rem;
  logic [QW-1:0]         quo;
  logic [DATA_WIDTH-1:0] x [NUM_CLASSES];

  logic                  in_hs;
  logic [SUM_W:0]        rem_shift;
  logic [SUM_W:0]        rem_sub;
  logic                  qbit;
  logic [SUM_W-1:0]      rem_next;
  logic [QW-1:0]         quo_next;

  // Input is only accepted while collecting and never while reset is asserted.
  assign norm_ready_in = (state == COLLECT) && !rst;
  assign in_hs         = norm_valid_in && norm_ready_in;

  // One restoring-division step. A zero divisor forces every quotient bit to 0.
  always_comb begin
    rem_shift = {rem, dvd[QW-1]};
    rem_sub   = rem_shift - {1'b0, acc};
    qbit      = (acc != '0) && (rem_shift >= {1'b0, acc});
    rem_next  = qbit ? rem_sub[SUM_W-1:0] : rem_shift[SUM_W-1:0];
    quo_next  = {quo[QW-2:0], qbit};
  end

  // Sample storage. This is a pure datapath array and needs no reset.
  always_ff @(posedge clk) begin
    if (in_hs) x[k] <= norm_data_in;
  end

  // Control FSM with the divider and the registered output stage.
  // In DIVIDE, cnt==0 loads the dividend. cnt 1..QW then each produce one quotient bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= COLLECT;
      k              <= '0;
      acc            <= '0;
      cnt            <= '0;
      dvd            <= '0;
      rem            <= '0;
      quo            <= '0;
      norm_valid_out <= 1'b0;
      norm_data_out  <= '0;
      norm_last_out  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_hs) begin
            acc <= acc + SUM_W'(norm_data_in);
            if (k == K_LAST) begin
              state <= DIVIDE;
              k     <= '0;
              cnt   <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (cnt == '0) begin
            dvd <= QW'(x[k]) << FRACTION;
            rem <= '0;
            quo <= '0;
            cnt <= cnt + 1'b1;
          end else begin
            dvd <= dvd << 1;
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == CNT_LAST) begin
              state          <= OUTPUT;
              cnt            <= '0;
              norm_valid_out <= 1'b1;
              norm_data_out  <= quo_next[DATA_WIDTH-1:0];
              norm_last_out  <= (k == K_LAST);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (norm_ready_out) begin
            norm_valid_out <= 1'b0;
            norm_last_out  <= 1'b0;
            if (k == K_LAST) begin
              state <= COLLECT;
              k     <= '0;
              acc   <= '0;
            end else begin
              state <= DIVIDE;
              k     <= k + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_val;
  logic [KW-1:0]         max_idx;
  logic                  new_max;

  // A strictly greater value is required to replace the current maximum, so the lowest index wins ties.
  assign new_max = (k == '0) || (norm_data_in > max_val);

  // Track the running maximum. The published index changes only when the vector completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val         <= '0;
      max_idx         <= '0;
      norm_argmax_out <= '0;
    end else if (in_hs) begin
      if (new_max) begin
        max_val <= norm_data_in;
        max_idx <= k;
      end
      if (k == K_LAST) norm_argmax_out <= new_max ? k : max_idx;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: table-driven, reset and randomized checks for softmax_norm.
// The argmax checks are included when SOFTMAX_ARGMAX_EN is defined.
module tb_softmax_norm;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int FR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          norm_ready_in;
  logic          norm_valid_in;
  logic [DW-1:0] norm_data_in;
  logic          norm_ready_out;
  logic          norm_valid_out;
  logic [DW-1:0] norm_data_out;
  logic          norm_last_out;
`ifdef SOFTMAX_ARGMAX_EN
  logic [1:0]    norm_argmax_out;
`endif

  softmax_norm #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .FRACTION(FR)) dut (
    .clk            (clk),
    .rst            (rst),
    .norm_ready_in  (norm_ready_in),
    .norm_valid_in  (norm_valid_in),
    .norm_data_in   (norm_data_in),
    .norm_ready_out (norm_ready_out),
    .norm_valid_out (norm_valid_out),
    .norm_data_out  (norm_data_out),
    .norm_last_out  (norm_last_out)
`ifdef SOFTMAX_ARGMAX_EN
    ,
    .norm_argmax_out(norm_argmax_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0][DW-1:0] din;
    logic [NC-1:0][DW-1:0] dout;
    logic [1:0]            arg;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] in_vec [NC];
  logic [DW-1:0] exp_vec [NC];
  int            exp_arg;
  vec_t          tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] a0, a1, a2, a3,
                              input logic [DW-1:0] e0, e1, e2, e3, input logic [1:0] arg);
    vec_t v;
    v.din[0] = a0; v.din[1] = a1; v.din[2] = a2; v.din[3] = a3;
    v.dout[0] = e0; v.dout[1] = e1; v.dout[2] = e2; v.dout[3] = e3;
    v.arg = arg;
    return v;
  endfunction

  // Reference: probability = floor(x * 2^FR / sum), zero when sum is zero; argmax = first maximum.
  function automatic void model();
    longint s = 0;
    for (int i = 0; i < NC; i++) s += longint'(in_vec[i]);
    for (int i = 0; i < NC; i++)
      exp_vec[i] = (s == 0) ? '0 : DW'((longint'(in_vec[i]) * (longint'(1) << FR)) / s);
    exp_arg = 0;
    for (int i = 1; i < NC; i++)
      if (in_vec[i] > in_vec[exp_arg]) exp_arg = i;
  endfunction

  task automatic send_vec();
    int i = 0;
    int guard = 0;
    logic hs;
    while (i < NC && guard < 100) begin
      norm_valid_in = 1'b1;
      norm_data_in  = in_vec[i];
      hs = norm_ready_in;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    norm_valid_in = 1'b0;
    if (i < NC) begin
      checks++; failures++;
      $display("FAIL send_timeout accepted=%0d required=%0d", i, NC);
    end
  endtask

  task automatic recv_vec(input int stall, input int lat_exp);
    int cyc;
    logic [DW-1:0] held;
    // Junk on the input side must be ignored while the vector is being processed.
    norm_valid_in = 1'b1;
    norm_data_in  = 16'hBEEF;
    for (int b = 0; b < NC; b++) begin
      norm_ready_out = (stall == 0);
      cyc = 0;
      while (!norm_valid_out && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (!norm_valid_out) begin
        checks++; failures++;
        $display("FAIL recv_timeout beat=%0d waited=%0d", b, cyc);
        norm_valid_in = 1'b0;
        return;
      end
      if (b == 0) check("latency", cyc, lat_exp);
      held = norm_data_out;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("stall_valid", norm_valid_out, 1);
        check("stall_data", norm_data_out, held);
        check("stall_ready_in", norm_ready_in, 0);
      end
      check("data", norm_data_out, exp_vec[b]);
      check("last", norm_last_out, (b == NC - 1));
`ifdef SOFTMAX_ARGMAX_EN
      check("argmax", norm_argmax_out, exp_arg);
`endif
      check("busy_ready_in", norm_ready_in, 0);
      norm_ready_out = 1'b1;
      @(posedge clk); #1;
    end
    norm_valid_in = 1'b0;
    check("done_valid", norm_valid_out, 0);
    check("done_ready_in", norm_ready_in, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;
    norm_valid_in  = 1'b0;
    norm_data_in   = '0;
    norm_ready_out = 1'b0;

    tbl[0] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 2'd0);
    tbl[1] = mk(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    tbl[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    tbl[3] = mk(16'h0080, 16'h0180, 16'h0000, 16'h0000, 16'h0040, 16'h00C0, 16'h0000, 16'h0000, 2'd1);
    tbl[4] = mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd25, 16'd51, 16'd76, 16'd102, 2'd3);
    tbl[5] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 2'd0);
    tbl[6] = mk(16'h0010, 16'h0300, 16'h0300, 16'h0020, 16'd2, 16'd124, 16'd124, 16'd5, 2'd1);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", norm_valid_out, 0);
    check("rst_data", norm_data_out, 0);
    check("rst_last", norm_last_out, 0);
    check("rst_ready_in", norm_ready_in, 0);
`ifdef SOFTMAX_ARGMAX_EN
    check("rst_argmax", norm_argmax_out, 0);
`endif
    rst = 1'b0;
    #1;
    check("rel_ready_in", norm_ready_in, 1);
    @(posedge clk); #1;

    // Directed table
    for (int n = 0; n < 7; n++) begin
      for (int i = 0; i < NC; i++) begin
        in_vec[i]  = tbl[n].din[i];
        exp_vec[i] = tbl[n].dout[i];
      end
      exp_arg = int'(tbl[n].arg);
      send_vec();
      recv_vec((n == 3) ? 5 : 0, 25);
    end

    // Reset in the middle of the second division
    for (int i = 0; i < NC; i++) in_vec[i] = 16'h0100;
    model();
    send_vec();
    norm_ready_out = 1'b1;
    cyc = 0;
    while (!norm_valid_out && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_first_data", norm_data_out, 16'h0040);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", norm_valid_out, 0);
    check("mid_rst_ready_in", norm_ready_in, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_ready_in", norm_ready_in, 1);
    check("mid_rel_valid", norm_valid_out, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (norm_valid_out) seen = 1'b1;
    end
    check("no_stale_output", seen, 0);
    send_vec();
    recv_vec(0, 25);

    // Randomized vectors against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NC; i++) begin
        case (r % 4)
          0: in_vec[i] = DW'($urandom_range(0, 15));
          1: in_vec[i] = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom_range(0, 65535));
          default: in_vec[i] = DW'($urandom_range(0, 65535));
        endcase
      end
      model();
      send_vec();
      recv_vec(int'($urandom_range(0, 3)), 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of exp values per softmax vector (2..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, unsigned fixed-point sample width.
REQ-003 SHALL have parameter FRACTION, default 8, fractional bits of the fixed-point format.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port norm_ready_in  output  1  block can accept an input beat.
REQ-007 SHALL have port norm_valid_in  input  1  norm_data_in is valid.
REQ-008 SHALL have port norm_data_in  input  DATA_WIDTH  exp value from the upstream exp stage.
REQ-009 SHALL have port norm_ready_out  input  1  downstream accepts output.
REQ-010 SHALL have port norm_valid_out  output  1  norm_data_out is valid.
REQ-011 SHALL have port norm_data_out  output  DATA_WIDTH  normalised probability, same Q format.
REQ-012 SHALL have port norm_last_out  output  1  high with the beat for class NUM_CLASSES-1.

Function
REQ-013 SHALL be a handshake: a beat transfers on a cycle where valid and ready are both high.
REQ-014 SHALL implement states COLLECT, DIVIDE, OUTPUT; norm_ready_in high only in COLLECT.
REQ-015 In COLLECT it SHALL store each accepted beat at index k (0..NUM_CLASSES-1) and add it to an accumulator of DATA_WIDTH+clog2(NUM_CLASSES) bits with no overflow or saturation.
REQ-016 On acceptance of beat NUM_CLASSES-1 it SHALL move to DIVIDE with k=0; the sum is then frozen.
REQ-017 DIVIDE SHALL compute floor((x[k] << FRACTION) / sum) with a restoring divider, one quotient bit per cycle, for exactly DATA_WIDTH+FRACTION cycles, then move to OUTPUT.
REQ-018 A sum of zero SHALL yield quotient 0; it SHALL NOT stall or produce X.
REQ-019 In OUTPUT norm_valid_out SHALL be high and norm_data_out/norm_last_out stable until the handshake.
REQ-020 After the OUTPUT handshake it SHALL go to DIVIDE for k+1, or to COLLECT with the accumulator cleared after k=NUM_CLASSES-1.
REQ-021 The first output SHALL be valid DATA_WIDTH+FRACTION+1 cycles after the last input handshake when norm_ready_out is held high.
REQ-022 Results SHALL be at most 1<<FRACTION; the upper quotient bits SHALL be zero-extended into DATA_WIDTH.
REQ-023 norm_valid_in in DIVIDE or OUTPUT SHALL be ignored; no input is lost because norm_ready_in is low.

Reset
REQ-024 rst SHALL force COLLECT, k=0, accumulator 0, divider cleared, and norm_valid_out=0, norm_data_out=0, norm_last_out=0 on the next edge.
REQ-025 norm_ready_in SHALL be 0 while rst is high and 1 in the first cycle after rst is released.
REQ-026 Reset in any state SHALL discard the partial vector, and no stale output SHALL appear afterwards.

Configuration
REQ-027 Macro SOFTMAX_ARGMAX_EN SHALL add port norm_argmax_out (output, clog2(NUM_CLASSES) bits).
REQ-028 With SOFTMAX_ARGMAX_EN, the block SHALL track the index of the largest input during COLLECT, keeping the lowest index on ties. It SHALL present that index on norm_argmax_out, stable across every OUTPUT beat of the vector, and reset it to 0.
REQ-029 Without SOFTMAX_ARGMAX_EN, the port and its comparison logic SHALL be absent and all other behaviour SHALL be identical.

Verification (NUM_CLASSES=4, DATA_WIDTH=16, FRACTION=8)
REQ-030 Inputs 0x0100 x4, ready_out high -> outputs 0x0040 x4, last on the 4th, first valid 25 cycles after the last input.
REQ-031 Inputs 0x0100,0,0,0 -> outputs 0x0100,0,0,0; inputs all 0 -> outputs 0,0,0,0 with no hang.
REQ-032 Vector 0x0080,0x0180,0,0 with ready_out low for 5 cycles at each output -> 0x0040,0x00C0,0,0 held stable, none dropped or duplicated; norm_ready_in stays 0 until the vector completes.
REQ-033 Assert rst mid-DIVIDE of the 2nd output -> valid_out 0, ready_in 1 after release; the next vector 0x0100 x4 gives 0x0040 x4.
REQ-034 With SOFTMAX_ARGMAX_EN, inputs 0x0010,0x0300,0x0300,0x0020 -> norm_argmax_out=1 on all 4 outputs.
